// File: rtl/mwb_pkg.sv
// mwb_pkg: shared definitions for the multicycle write-back controller.
//   - RV32I opcode constants for the supported instruction classes
//   - FSM state encoding (3-bit, also exported on the debug port)
//   - write-back mux and next-PC mux select encodings
//   - op-class enum produced by mwb_op_decode
package mwb_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  typedef enum logic [2:0] {
    OC_R, OC_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL, OC_JALR, OC_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/mwb_op_decode.sv
// mwb_op_decode: combinational opcode classifier.
//   opcode   in  7  IR[6:0]
//   op_class out    instruction class, OC_ILLEGAL for unsupported opcodes
module mwb_op_decode
  import mwb_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = OC_ILLEGAL;
    case (opcode)
      OP_R:      op_class = OC_R;
      OP_I:      op_class = OC_I;
      OP_LOAD:   op_class = OC_LOAD;
      OP_STORE:  op_class = OC_STORE;
      OP_BRANCH: op_class = OC_BRANCH;
      OP_JAL:    op_class = OC_JAL;
      OP_JALR:   op_class = OC_JALR;
      default:   op_class = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_wb_ctrl.sv
// multicycle_wb_ctrl: multicycle RV32I control FSM
// (FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK]).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode, rd              IR fields (valid from DECODE onward)
//   branch_taken            ALU compare result, used in EXECUTE
//   imem_req / imem_ready   instruction fetch handshake
//   dmem_req / dmem_we / dmem_ready  data access handshake
//   ir_we, pc_we, pc_src    IR / PC load strobes and next-PC select
//   wb_sel, reg_we          write-back mux select and register write enable
//   state                   current state (debug)
//   illegal, bus_err, retire  one-cycle event pulses
//   retire_count            retired-instruction counter (only with RETIRE_CNT_EN)
// Optional feature macro: RETIRE_CNT_EN.
module multicycle_wb_ctrl
  import mwb_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       reg_we,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err,
  output logic       retire
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  // The timeout fires on the (2^TIMEOUT_W - 1)-th consecutive cycle without
  // ready, i.e. when the count of earlier waiting cycles equals 2^TIMEOUT_W - 2.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic                  wait_expired;
  op_class_t             op_class;

  mwb_op_decode u_dec (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign wait_expired = (wait_q == WAIT_LAST);
  assign state        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // wait_d defaults to 0, so the counter is clear on every entry to FETCH or
  // MEMORY and after every ready or timeout.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    wb_sel   = WB_ALU;
    reg_we   = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Reset forces FETCH; keep the request and its strobes quiet until release.
        imem_req = rst_n;
        if (rst_n) begin
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (wait_expired) begin
            bus_err = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (op_class == OC_ILLEGAL) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (op_class)
          OC_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? PC_TARGET : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OC_LOAD, OC_STORE:              state_d = S_MEMORY;
          OC_R, OC_I, OC_JAL, OC_JALR:    state_d = S_WRITEBACK;
          default:                        state_d = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == OC_STORE);
        if (dmem_ready) begin
          if (op_class == OC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_expired) begin
          // Abandon the access and move on to the next PC without writing back.
          bus_err = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_we = (rd != 5'd0);
        pc_we  = 1'b1;
        retire = 1'b1;
        case (op_class)
          OC_LOAD: wb_sel = WB_MEM;
          OC_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_TARGET;
          end
          OC_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          default: wb_sel = WB_ALU;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_count <= '0;
    else if (retire) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_wb_ctrl.sv
// tb_multicycle_wb_ctrl: directed bench for multicycle_wb_ctrl.
// An instruction-level model expands each directed instruction into the
// cycle-by-cycle output trace it must produce; one compare process checks the
// DUT against that trace every cycle, checks the reset values while rst_n is
// low, and finally checks the instruction latencies against hand-computed values.
`timescale 1ns/1ps
module tb_multicycle_wb_ctrl;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;   // 15 waiting cycles -> timeout
  localparam int NLIT  = 14;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [4:0] rd;
  logic       branch_taken;
  logic       imem_req, imem_ready;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       ir_we, pc_we, reg_we;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;
  logic       illegal, bus_err, retire;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  multicycle_wb_ctrl #(.TIMEOUT_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .rd           (rd),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .reg_we       (reg_we),
    .state        (state),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .retire       (retire)
`ifdef RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] st;
    logic       illegal, bus_err, retire;
  } exp_t;

  exp_t  e;
  logic  chk_en;
  logic  noise;
  logic  fin, fin_done;
  int    cyc, nret;
  int    lit_act [NLIT];
  string lit_name [NLIT];
  localparam int LIT_EXP [NLIT] = '{6, 4, 8, 4, 3, 18, 2, 20, 4, 3, 5, 5, 9, 3};
  int    vectors, errors, mdl_rc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst.state",    32'(state),    32'd0);
      check("rst.imem_req", 32'(imem_req), 32'd0);
      check("rst.dmem_req", 32'(dmem_req), 32'd0);
      check("rst.ir_we",    32'(ir_we),    32'd0);
      check("rst.pc_we",    32'(pc_we),    32'd0);
      check("rst.reg_we",   32'(reg_we),   32'd0);
      check("rst.retire",   32'(retire),   32'd0);
      check("rst.bus_err",  32'(bus_err),  32'd0);
      mdl_rc = 0;
`ifdef RETIRE_CNT_EN
      check("rst.retire_count", retire_count, 32'd0);
`endif
    end else if (chk_en) begin
      check("state",    32'(state),    32'(e.st));
      check("imem_req", 32'(imem_req), 32'(e.imem_req));
      check("dmem_req", 32'(dmem_req), 32'(e.dmem_req));
      check("dmem_we",  32'(dmem_we),  32'(e.dmem_we));
      check("ir_we",    32'(ir_we),    32'(e.ir_we));
      check("pc_we",    32'(pc_we),    32'(e.pc_we));
      check("pc_src",   32'(pc_src),   32'(e.pc_src));
      check("wb_sel",   32'(wb_sel),   32'(e.wb_sel));
      check("reg_we",   32'(reg_we),   32'(e.reg_we));
      check("illegal",  32'(illegal),  32'(e.illegal));
      check("bus_err",  32'(bus_err),  32'(e.bus_err));
      check("retire",   32'(retire),   32'(e.retire));
`ifdef RETIRE_CNT_EN
      check("retire_count", retire_count, 32'(mdl_rc));
`endif
      if (e.retire) mdl_rc++;
    end
    if (fin && !fin_done) begin
      for (int i = 0; i < NLIT; i++) check(lit_name[i], 32'(lit_act[i]), 32'(LIT_EXP[i]));
      fin_done = 1'b1;
    end
  end

  function automatic int cls(input logic [6:0] o);
    case (o)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  task automatic clr(input int st);
    e = '{default: '0};
    e.st = 3'(st);
  endtask

  task automatic tick();
    if (e.retire) nret++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Expands one instruction into its expected per-cycle trace while driving it.
  // dwait < 0: dmem_ready never comes. abort_at >= 0: stop before that MEMORY cycle.
  task automatic run_instr(input logic [6:0] opc, input logic [4:0] rdv, input logic tk,
                           input int iwait, input int dwait, input int abort_at);
    int c, k, w;
    c = cls(opc);
    chk_en = 1'b1;
    rd = rdv;
    branch_taken = noise ? ~tk : tk;
    opcode = 7'h00;   // IR not loaded yet: controller must ignore it in FETCH
    k = 0; w = 0;
    while (1) begin
      clr(0); e.imem_req = 1'b1;
      imem_ready = (k >= iwait); dmem_ready = noise;
      if (imem_ready) begin e.ir_we = 1'b1; tick(); break; end
      if (w == LIMIT - 1) begin e.bus_err = 1'b1; w = 0; end else w++;
      k++; tick();
    end
    clr(1); opcode = opc; imem_ready = noise; dmem_ready = noise;
    if (c == C_ILL) begin e.illegal = 1'b1; e.pc_we = 1'b1; tick(); return; end
    tick();
    clr(2); branch_taken = tk;
    if (c == C_BR) begin
      e.pc_we = 1'b1; e.pc_src = tk ? 2'd1 : 2'd0; e.retire = 1'b1; tick();
      branch_taken = noise ? ~tk : tk;
      return;
    end
    tick();
    branch_taken = noise ? ~tk : tk;
    if (c == C_LD || c == C_ST) begin
      k = 0; w = 0;
      while (1) begin
        if (abort_at >= 0 && k == abort_at) begin chk_en = 1'b0; return; end
        clr(3); e.dmem_req = 1'b1; e.dmem_we = (c == C_ST);
        dmem_ready = (dwait >= 0 && k >= dwait); imem_ready = noise;
        if (dmem_ready) begin
          if (c == C_ST) begin e.pc_we = 1'b1; e.retire = 1'b1; tick(); return; end
          tick(); break;
        end
        if (w == LIMIT - 1) begin e.bus_err = 1'b1; e.pc_we = 1'b1; tick(); return; end
        w++; k++; tick();
      end
    end
    clr(4); imem_ready = noise; dmem_ready = noise;
    e.reg_we = (rdv != 5'd0); e.pc_we = 1'b1; e.retire = 1'b1;
    e.wb_sel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    e.pc_src = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
    tick();
  endtask

  task automatic timed(input int idx, input string name, input logic [6:0] opc,
                       input logic [4:0] rdv, input logic tk, input int iwait, input int dwait);
    int c0;
    c0 = cyc;
    run_instr(opc, rdv, tk, iwait, dwait, -1);
    lit_act[idx]  = cyc - c0;
    lit_name[idx] = name;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vectors = 0; errors = 0; mdl_rc = 0; cyc = 0; nret = 0;
    chk_en = 1'b0; noise = 1'b0; fin = 1'b0; fin_done = 1'b0;
    e = '{default: '0};
    rst_n = 1'b0; opcode = 7'h33; rd = 5'd1; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;   // ready during reset must not leak through
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    timed(0, "lat.addi_iwait2",   7'b0010011, 5'd1, 1'b0, 2, 0);
    timed(1, "lat.add_rd5",       7'b0110011, 5'd5, 1'b0, 0, 0);
    timed(2, "lat.lw_rd3_dwait3", 7'b0000011, 5'd3, 1'b0, 0, 3);
    timed(3, "lat.jalr_rd0",      7'b1100111, 5'd0, 1'b0, 0, 0);
    timed(4, "lat.beq_taken",     7'b1100011, 5'd0, 1'b1, 0, 0);
    timed(5, "lat.sw_timeout",    7'b0100011, 5'd0, 1'b0, 0, -1);
    timed(6, "lat.illegal",       7'b0000000, 5'd4, 1'b0, 0, 0);
    timed(7, "lat.fetch_timeout", 7'b0110011, 5'd6, 1'b0, 16, 0);

    noise = 1'b1;   // stray ready / branch_taken outside their own states
    timed(8,  "lat.jal_rd7_noise", 7'b1101111, 5'd7, 1'b0, 0, 0);
    timed(9,  "lat.bne_nt_noise",  7'b1100011, 5'd0, 1'b0, 0, 0);
    timed(10, "lat.sw_dwait1",     7'b0100011, 5'd0, 1'b0, 0, 1);
    timed(11, "lat.lw_rd0_noise",  7'b0000011, 5'd0, 1'b0, 0, 0);
    noise = 1'b0;

    // Reset asserted in the middle of a load's MEMORY wait.
    run_instr(7'b0000011, 5'd8, 1'b0, 0, -1, 2);
    rst_n = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ten mixed instructions, one illegal.
    nret = 0;
    run_instr(7'b0110011, 5'd2, 1'b0, 0, 0, -1);
    run_instr(7'b1111111, 5'd2, 1'b0, 0, 0, -1);
    run_instr(7'b0000011, 5'd4, 1'b0, 1, 0, -1);
    run_instr(7'b0100011, 5'd0, 1'b0, 0, 2, -1);
    run_instr(7'b1100011, 5'd0, 1'b0, 0, 0, -1);
    run_instr(7'b1101111, 5'd1, 1'b0, 0, 0, -1);
    run_instr(7'b1100111, 5'd9, 1'b0, 0, 0, -1);
    run_instr(7'b0010011, 5'd3, 1'b0, 0, 0, -1);
    run_instr(7'b1100011, 5'd0, 1'b1, 0, 0, -1);
    c0 = cyc;
    run_instr(7'b0000011, 5'd0, 1'b0, 0, 1, -1);
    lit_act[12] = nret;       lit_name[12] = "model.retires_of_10";
    lit_act[13] = cyc - c0;   lit_name[13] = "lat.lw_dwait1";
    lit_act[13] = lit_act[13] - 3;   // 6-cycle load minus FETCH/DECODE/EXECUTE
    chk_en = 1'b0;

    fin = 1'b1;
    repeat (3) @(negedge clk);
    if (!fin_done) begin
      $display("FAIL final_checks: not completed");
      $fatal(1, "final checks");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
